stream_downsizer: RTL and testbench

- Width-reducing valid/ready stream stage. Accepts one IN_WIDTH-bit word per handshake and emits it as up to RATIO narrow OUT_WIDTH-bit beats, least-significant slice first.
- Sits directly upstream of a regslice on narrow datapaths, for example a 64-bit bus narrowed to a 16-bit peripheral link. Its r_* port feeds the regslice w_* port.
- Carries an optional partial-word beat count and a packet-end marker.

---
 rtl/stream_downsizer.sv | 76 +++++++
 tb/tb_stream_downsizer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// Width-reducing valid/ready stage: one IN_WIDTH word in, up to RATIO
// OUT_WIDTH beats out, least-significant slice first.
module stream_downsizer #(
   parameter  int IN_WIDTH  = 64,
   parameter  int RATIO     = 4,
   localparam int OUT_WIDTH = IN_WIDTH / RATIO,
   localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [IN_WIDTH-1:0]  w_data,
   input  logic [CNT_W-1:0]     w_beats,
   input  logic                 w_last,
   output logic                 r_valid,
   input  logic                 r_ready,
   output logic [OUT_WIDTH-1:0] r_data,
   output logic                 r_last
);

   generate
      if (RATIO < 1 || (RATIO & (RATIO - 1)) != 0 || (IN_WIDTH % RATIO) != 0) begin : g_bad_params
         $error("stream_downsizer: RATIO must be a power of two dividing IN_WIDTH");
      end
   endgenerate

   // Handshake: a transfer happens on a rising clk edge where valid && ready.
   // w_ready depends only on registered state and r_ready, never on w_valid.
   logic                valid_q;
   logic [CNT_W-1:0]    idx_q;
   logic [IN_WIDTH-1:0] data_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                last_q;

   logic final_beat;
   logic accept;
   logic beat_xfer;

   assign final_beat = (idx_q == cnt_q);
   assign w_ready    = !valid_q || (r_ready && final_beat);
   assign accept     = w_valid && w_ready;
   assign beat_xfer  = valid_q && r_ready;

   assign r_valid = valid_q;
   assign r_data  = data_q[idx_q * OUT_WIDTH +: OUT_WIDTH];
   assign r_last  = last_q && final_beat;

   // A load always wins over retiring the final beat, so words stream without a bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         idx_q   <= '0;
      end else if (beat_xfer) begin
         if (final_beat) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   // Payload registers carry no reset; they are only observed while valid_q is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= w_data;
         cnt_q  <= (RATIO == 1) ? '0 : w_beats;
         last_q <= w_last;
      end
   end

endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: a 64->16 instance (RATIO=4) and a 16->16
// instance (RATIO=1), each checked against an expected-beat queue.
module tb_stream_downsizer;

   logic clk;
   logic rstn;

   logic        a_w_valid, a_w_ready, a_w_last;
   logic [63:0] a_w_data;
   logic [1:0]  a_w_beats;
   logic        a_r_valid, a_r_ready, a_r_last;
   logic [15:0] a_r_data;

   logic        b_w_valid, b_w_ready, b_w_last;
   logic [15:0] b_w_data;
   logic [0:0]  b_w_beats;
   logic        b_r_valid, b_r_ready, b_r_last;
   logic [15:0] b_r_data;

   logic [16:0] exp_q_a[$];
   logic [16:0] exp_q_b[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic mon_en = 1'b0;
   logic acc_prev_a = 1'b0;
   logic acc_prev_b = 1'b0;

   stream_downsizer #(.IN_WIDTH(64), .RATIO(4)) u_dut_a (
      .clk(clk), .rstn(rstn),
      .w_valid(a_w_valid), .w_ready(a_w_ready), .w_data(a_w_data),
      .w_beats(a_w_beats), .w_last(a_w_last),
      .r_valid(a_r_valid), .r_ready(a_r_ready), .r_data(a_r_data), .r_last(a_r_last)
   );

   stream_downsizer #(.IN_WIDTH(16), .RATIO(1)) u_dut_b (
      .clk(clk), .rstn(rstn),
      .w_valid(b_w_valid), .w_ready(b_w_ready), .w_data(b_w_data),
      .w_beats(b_w_beats), .w_last(b_w_last),
      .r_valid(b_r_valid), .r_ready(b_r_ready), .r_data(b_r_data), .r_last(b_r_last)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (acc_prev_a) check("a_latency", a_r_valid, 1);
         if (a_r_valid) begin
            if (exp_q_a.size() == 0) check("a_extra_beat", 1, 0);
            else begin
               check("a_data", a_r_data, exp_q_a[0][15:0]);
               check("a_last", a_r_last, exp_q_a[0][16]);
               if (a_r_ready) void'(exp_q_a.pop_front());
            end
         end
         acc_prev_a = a_w_valid && a_w_ready;
         if (acc_prev_a) begin
            for (int k = 0; k <= int'(a_w_beats); k++)
               exp_q_a.push_back({a_w_last && (k == int'(a_w_beats)), a_w_data[k*16 +: 16]});
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (acc_prev_b) check("b_latency", b_r_valid, 1);
         if (b_r_valid) begin
            if (exp_q_b.size() == 0) check("b_extra_beat", 1, 0);
            else begin
               check("b_data", b_r_data, exp_q_b[0][15:0]);
               check("b_last", b_r_last, exp_q_b[0][16]);
               if (b_r_ready) void'(exp_q_b.pop_front());
            end
         end
         acc_prev_b = b_w_valid && b_w_ready;
         if (acc_prev_b) exp_q_b.push_back({b_w_last, b_w_data});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_a(input logic [63:0] d, input logic [1:0] beats, input logic last,
                         output int acc_cyc);
      int t = 0;
      a_w_valid = 1'b1; a_w_data = d; a_w_beats = beats; a_w_last = last;
      @(negedge clk);
      while (!a_w_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("a_send_timeout", 0, 1);
      @(posedge clk);
      acc_cyc = cyc;
      #1 a_w_valid = 1'b0;
   endtask

   task automatic send_b(input logic [15:0] d, input logic last);
      int t = 0;
      b_w_valid = 1'b1; b_w_data = d; b_w_last = last;
      @(negedge clk);
      while (!b_w_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("b_send_timeout", 0, 1);
      @(posedge clk);
      #1 b_w_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while ((a_r_valid || b_r_valid || exp_q_a.size() != 0 || exp_q_b.size() != 0) && t < 300) begin
         @(negedge clk); t++;
      end
      if (t >= 300) check("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ta, tb_acc, n, t, dummy;
      int pat[7];
      logic done;
      pat = '{1, 0, 0, 1, 1, 0, 1};

      rstn = 1'b0;
      a_w_valid = 0; a_w_data = '0; a_w_beats = '0; a_w_last = 0; a_r_ready = 1;
      b_w_valid = 0; b_w_data = '0; b_w_beats = '0; b_w_last = 0; b_r_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_r_valid", a_r_valid, 0);
      check("rst_a_w_ready", a_w_ready, 1);
      check("rst_b_r_valid", b_r_valid, 0);
      check("rst_b_w_ready", b_w_ready, 1);
      rstn = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Full word, no backpressure; w_ready low until the final beat
      send_a(64'h4444_3333_2222_1111, 2'd3, 1'b1, dummy);
      @(negedge clk); check("full_wready_b0", a_w_ready, 0);
      @(negedge clk); check("full_wready_b1", a_w_ready, 0);
      @(negedge clk); check("full_wready_b2", a_w_ready, 0);
      @(negedge clk); check("full_wready_b3", a_w_ready, 1);
      wait_idle();

      // Back-to-back words with no idle cycle
      fork
         begin
            send_a(64'hA004_A003_A002_A001, 2'd3, 1'b0, ta);
            send_a(64'hB004_B003_B002_B001, 2'd3, 1'b1, tb_acc);
         end
         begin
            n = 0; t = 0;
            while (!a_r_valid && t < 20) begin @(negedge clk); t++; end
            for (int i = 0; i < 8; i++) begin
               if (a_r_valid) n++;
               @(negedge clk);
            end
            check("b2b_contiguous", n, 8);
            check("b2b_end_valid", a_r_valid, 0);
         end
      join
      check("b2b_accept_gap", tb_acc - ta, 4);
      wait_idle();

      // Partial word: two beats only
      send_a(64'hDDDD_CCCC_BBBB_AAAA, 2'd1, 1'b0, dummy);
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("partial_done", a_r_valid, 0);
      wait_idle();

      // Backpressure pattern during a full word
      send_a(64'h7777_6666_5555_4444, 2'd3, 1'b1, dummy);
      for (int i = 0; i < 7; i++) begin
         a_r_ready = pat[i][0];
         @(posedge clk); #1;
      end
      a_r_ready = 1'b1;
      check("bp_drained", exp_q_a.size(), 0);
      wait_idle();

      // Reset mid-drain
      send_a(64'h9994_9993_9992_9991, 2'd3, 1'b1, dummy);
      @(posedge clk); #2;
      mon_en = 1'b0; acc_prev_a = 1'b0; acc_prev_b = 1'b0;
      rstn = 1'b0;
      #1;
      check("rst_mid_r_valid", a_r_valid, 0);
      check("rst_mid_w_ready", a_w_ready, 1);
      exp_q_a.delete(); exp_q_b.delete();
      @(posedge clk); #1 rstn = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check("rst_no_stale", a_r_valid, 0);
      end
      @(posedge clk); #1;
      send_a(64'h0D04_0D03_0D02_0D01, 2'd3, 1'b1, dummy);
      wait_idle();

      // Random words and random backpressure on the 4:1 instance
      done = 1'b0;
      fork
         begin
            for (int w = 0; w < 8; w++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send_a({$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), dummy);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1 a_r_ready = 1'($urandom_range(0, 1));
            end
            a_r_ready = 1'b1;
         end
      join
      wait_idle();

      // RATIO=1 instance: 10 words, random valid and ready
      done = 1'b0;
      fork
         begin
            for (int w = 0; w < 10; w++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send_b(16'($urandom), 1'($urandom_range(0, 1)));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1 b_r_ready = 1'($urandom_range(0, 1));
            end
            b_r_ready = 1'b1;
         end
      join
      wait_idle();

      check("final_q_a_empty", exp_q_a.size(), 0);
      check("final_q_b_empty", exp_q_b.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
